// File: rtl/router_pkg.sv
// Shared router types: port count, route encoding and the output allocation state.
package router_pkg;
    localparam int NUM_PORTS         = 5;
    localparam int NUM_OF_PORTS_BITS = $clog2(NUM_PORTS);

    // Route MSB set marks "no valid destination".
    typedef logic [NUM_OF_PORTS_BITS-1:0] ROUTE_t;

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } ALLOC_STATE_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output FREE/LOCKED lock with round-robin input selection.
module switch_allocator #(
    parameter int NUM_PORTS = router_pkg::NUM_PORTS,
    parameter int PW        = router_pkg::NUM_OF_PORTS_BITS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          i_switch_req,
    input  logic [NUM_PORTS-1:0][PW-1:0]  i_route,
    input  logic [NUM_PORTS-1:0]          i_packet_done,
    input  logic [NUM_PORTS-1:0]          i_out_ready,
    output logic [NUM_PORTS-1:0]          o_switch_ack,
    output logic [NUM_PORTS-1:0][PW-1:0]  o_xbar_sel,
    output logic [NUM_PORTS-1:0]          o_out_busy
);
    import router_pkg::*;

    ALLOC_STATE_t                        state [NUM_PORTS];
    logic [NUM_PORTS-1:0][PW-1:0]        owner;
    logic [NUM_PORTS-1:0][PW-1:0]        rr;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;
    logic [NUM_PORTS-1:0][PW-1:0]        gnt_idx;
    logic [NUM_PORTS-1:0]                grant_en;
    logic [NUM_PORTS-1:0]                holds_lock;
    logic [NUM_PORTS-1:0]                ack_next;

    always_comb begin
        holds_lock = '0;
        for (int j = 0; j < NUM_PORTS; j++)
            if (state[j] == LOCKED) holds_lock[owner[j]] = 1'b1;
    end

    // cand[j][i]: input i is eligible for output j this cycle.
    always_comb begin
        cand = '0;
        for (int j = 0; j < NUM_PORTS; j++)
            for (int i = 0; i < NUM_PORTS; i++)
                cand[j][i] = i_switch_req[i] && !i_route[i][PW-1] &&
                             (int'(i_route[i]) < NUM_PORTS) &&
                             (int'(i_route[i]) == j) && !holds_lock[i];
    end

    always_comb begin
        gnt_idx  = '0;
        grant_en = '0;
        ack_next = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            grant_en[j] = (state[j] == FREE) && i_out_ready[j] && (|gnt[j]);
            for (int i = 0; i < NUM_PORTS; i++)
                if (gnt[j][i]) begin
                    gnt_idx[j] = PW'(i);
                    if (grant_en[j]) ack_next[i] = 1'b1;
                end
        end
    end

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
        rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
            .req (cand[j]),
            .ptr (rr[j]),
            .gnt (gnt[j])
        );

        // Owner is cleared on release so it doubles as the registered crossbar select.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state[j] <= FREE;
                owner[j] <= '0;
                rr[j]    <= '0;
            end else begin
                case (state[j])
                    FREE: if (grant_en[j]) begin
                        state[j] <= LOCKED;
                        owner[j] <= gnt_idx[j];
                        rr[j]    <= (int'(gnt_idx[j]) == NUM_PORTS-1) ? '0 : gnt_idx[j] + 1'b1;
                    end
                    LOCKED: if (i_packet_done[owner[j]]) begin
                        state[j] <= FREE;
                        owner[j] <= '0;
                    end
                    default: state[j] <= FREE;
                endcase
            end
        end

        assign o_out_busy[j] = (state[j] == LOCKED);
    end

    assign o_xbar_sel = owner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) o_switch_ack <= '0;
        else          o_switch_ack <= ack_next;
    end
endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: vector tables through a scoreboard queue plus reset sequences.
module tb_switch_allocator;
    import router_pkg::*;

    localparam int N = 5;
    localparam int P = NUM_OF_PORTS_BITS;

    typedef logic [N-1:0][P-1:0] rt_t;
    typedef struct {
        string        nm;
        logic [N-1:0] req;
        rt_t          route;
        logic [N-1:0] done;
        logic [N-1:0] rdy;
        logic [N-1:0] ack;
        logic [N-1:0] busy;
        rt_t          sel;
    } vec_t;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] i_switch_req;
    rt_t          i_route;
    logic [N-1:0] i_packet_done;
    logic [N-1:0] i_out_ready;
    logic [N-1:0] o_switch_ack;
    rt_t          o_xbar_sel;
    logic [N-1:0] o_out_busy;

    switch_allocator #(.NUM_PORTS(N), .PW(P)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_switch_req  (i_switch_req),
        .i_route       (i_route),
        .i_packet_done (i_packet_done),
        .i_out_ready   (i_out_ready),
        .o_switch_ack  (o_switch_ack),
        .o_xbar_sel    (o_xbar_sel),
        .o_out_busy    (o_out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    function automatic rt_t r5(int a0, int a1, int a2, int a3, int a4);
        rt_t r;
        r[0] = P'(a0); r[1] = P'(a1); r[2] = P'(a2); r[3] = P'(a3); r[4] = P'(a4);
        return r;
    endfunction

    function automatic vec_t mk(string nm, logic [N-1:0] req, rt_t route, logic [N-1:0] done,
                                logic [N-1:0] rdy, logic [N-1:0] ack, logic [N-1:0] busy, rt_t sel);
        vec_t v;
        v.nm = nm; v.req = req; v.route = route; v.done = done;
        v.rdy = rdy; v.ack = ack; v.busy = busy; v.sel = sel;
        return v;
    endfunction

    task automatic check_now(string nm, logic [N-1:0] eack, logic [N-1:0] ebusy, rt_t esel);
        n_vec++;
        if (o_switch_ack !== eack || o_out_busy !== ebusy || o_xbar_sel !== esel) begin
            n_err++;
            $display("FAIL %s: got ack=%b busy=%b sel=%h, want ack=%b busy=%b sel=%h",
                     nm, o_switch_ack, o_out_busy, o_xbar_sel, eack, ebusy, esel);
        end
    endtask

    task automatic drive_idle();
        i_switch_req  = '0;
        i_route       = r5(4, 4, 4, 4, 4);
        i_packet_done = '0;
        i_out_ready   = '1;
    endtask

    // Drive one vector, let one edge sample it, compare against the queued expectation.
    task automatic step(vec_t v);
        vec_t e;
        i_switch_req  = v.req;
        i_route       = v.route;
        i_packet_done = v.done;
        i_out_ready   = v.rdy;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_now(e.nm, e.ack, e.busy, e.sel);
    endtask

    task automatic run_tbl();
        for (int k = 0; k < tbl.size(); k++) step(tbl[k]);
        tbl.delete();
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        #1;
        check_now("reset_state", '0, '0, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    localparam rt_t Z  = '0;
    localparam rt_t IV = '1;

    initial begin
        drive_idle();
        reset_n = 1'b0;
        #2;
        do_reset();

        // Single packet, then parallel grants to distinct outputs.
        tbl.push_back(mk("single_grant", 5'b00001, r5(2,4,4,4,4), 5'b00000, 5'h1F, 5'b00001, 5'b00100, Z));
        tbl.push_back(mk("single_hold",  5'b00000, IV,            5'b00000, 5'h1F, 5'b00000, 5'b00100, Z));
        tbl.push_back(mk("single_done",  5'b00000, IV,            5'b00001, 5'h1F, 5'b00000, 5'b00000, Z));
        tbl.push_back(mk("idle",         5'b00000, IV,            5'b00000, 5'h1F, 5'b00000, 5'b00000, Z));
        tbl.push_back(mk("par_grant",    5'b00111, r5(1,0,3,4,4), 5'b00000, 5'h1F, 5'b00111, 5'b01011, r5(1,0,0,2,0)));
        tbl.push_back(mk("par_hold",     5'b00000, IV,            5'b00000, 5'h1F, 5'b00000, 5'b01011, r5(1,0,0,2,0)));
        tbl.push_back(mk("par_done",     5'b00000, IV,            5'b00111, 5'h1F, 5'b00000, 5'b00000, Z));
        tbl.push_back(mk("inval_100",    5'b00001, r5(4,4,4,4,4), 5'b00000, 5'h1F, 5'b00000, 5'b00000, Z));
        tbl.push_back(mk("inval_111",    5'b00001, r5(7,4,4,4,4), 5'b00000, 5'h1F, 5'b00000, 5'b00000, Z));
        run_tbl();

        do_reset();
        // Contention on output 0 from inputs 1,3,4; rr[0] starts at 0 and wraps after 4.
        tbl.push_back(mk("cont_g1",      5'b11010, r5(4,0,4,0,0), 5'b00000, 5'h1F, 5'b00010, 5'b00001, r5(1,0,0,0,0)));
        tbl.push_back(mk("cont_nonown",  5'b11000, r5(4,4,4,0,0), 5'b01000, 5'h1F, 5'b00000, 5'b00001, r5(1,0,0,0,0)));
        tbl.push_back(mk("cont_rel1",    5'b11000, r5(4,4,4,0,0), 5'b00010, 5'h1F, 5'b00000, 5'b00000, Z));
        tbl.push_back(mk("cont_g3",      5'b11000, r5(4,4,4,0,0), 5'b00000, 5'h1F, 5'b01000, 5'b00001, r5(3,0,0,0,0)));
        tbl.push_back(mk("cont_rel3",    5'b10000, r5(4,4,4,4,0), 5'b01000, 5'h1F, 5'b00000, 5'b00000, Z));
        tbl.push_back(mk("cont_g4",      5'b10000, r5(4,4,4,4,0), 5'b00000, 5'h1F, 5'b10000, 5'b00001, r5(4,0,0,0,0)));
        tbl.push_back(mk("cont_rel4",    5'b00000, IV,            5'b10000, 5'h1F, 5'b00000, 5'b00000, Z));
        tbl.push_back(mk("wrap_g1",      5'b10010, r5(4,0,4,4,0), 5'b00000, 5'h1F, 5'b00010, 5'b00001, r5(1,0,0,0,0)));
        tbl.push_back(mk("wrap_rel1",    5'b10000, r5(4,4,4,4,0), 5'b00010, 5'h1F, 5'b00000, 5'b00000, Z));
        tbl.push_back(mk("wrap_g4",      5'b10000, r5(4,4,4,4,0), 5'b00000, 5'h1F, 5'b10000, 5'b00001, r5(4,0,0,0,0)));
        tbl.push_back(mk("wrap_rel4",    5'b00000, IV,            5'b10000, 5'h1F, 5'b00000, 5'b00000, Z));
        // Non-owner done on output 2 while input 1 owns it; pending input 0 waits for the release edge.
        tbl.push_back(mk("own2_g1",      5'b00010, r5(4,2,4,4,4), 5'b00000, 5'h1F, 5'b00010, 5'b00100, r5(0,0,1,0,0)));
        tbl.push_back(mk("own2_done3",   5'b00001, r5(2,4,4,4,4), 5'b01000, 5'h1F, 5'b00000, 5'b00100, r5(0,0,1,0,0)));
        tbl.push_back(mk("own2_rel1",    5'b00001, r5(2,4,4,4,4), 5'b00010, 5'h1F, 5'b00000, 5'b00000, Z));
        tbl.push_back(mk("own2_g0",      5'b00001, r5(2,4,4,4,4), 5'b00000, 5'h1F, 5'b00001, 5'b00100, Z));
        tbl.push_back(mk("own2_rel0",    5'b00000, IV,            5'b00001, 5'h1F, 5'b00000, 5'b00000, Z));
        run_tbl();

        // Backpressure: output 2 not ready for 10 cycles.
        for (int k = 0; k < 10; k++)
            step(mk("bp_hold", 5'b10000, r5(4,4,4,4,2), 5'b00000, 5'b11011, 5'b00000, 5'b00000, Z));
        step(mk("bp_ready", 5'b10000, r5(4,4,4,4,2), 5'b00000, 5'h1F, 5'b10000, 5'b00100, r5(0,0,4,0,0)));
        step(mk("bp_rel",   5'b00000, IV,            5'b10000, 5'h1F, 5'b00000, 5'b00000, Z));

        // Asynchronous reset while an ack pulse and a lock are active.
        step(mk("rst_pre", 5'b01000, r5(4,4,4,0,4), 5'b00000, 5'h1F, 5'b01000, 5'b00001, r5(3,0,0,0,0)));
        drive_idle();
        #1;
        reset_n = 1'b0;
        #1;
        check_now("rst_async", '0, '0, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(mk("rst_ptr0", 5'b10010, r5(4,0,4,4,0), 5'b00000, 5'h1F, 5'b00010, 5'b00001, r5(1,0,0,0,0)));
        step(mk("rst_rel",  5'b00000, IV,            5'b00010, 5'h1F, 5'b00000, 5'b00000, Z));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, want completion");
        $fatal(1);
    end
endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, giving the number of router ports; input index equals output index.
REQ-002 SHALL have parameter PW, default NUM_OF_PORTS_BITS from router_pkg, giving the route field width; route MSB=1 means invalid.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_switch_req  input  NUM_PORTS  per-input switch request, held by the input unit while routing.
REQ-006 SHALL have port i_route  input  NUM_PORTS x PW (ROUTE_t array)  requested output port per input.
REQ-007 SHALL have port i_packet_done  input  NUM_PORTS  per-input tail-flit-sent pulse.
REQ-008 SHALL have port i_out_ready  input  NUM_PORTS  per-output downstream credit available.
REQ-009 SHALL have port o_switch_ack  output  NUM_PORTS  per-input one-cycle grant pulse.
REQ-010 SHALL have port o_xbar_sel  output  NUM_PORTS x PW  per-output selected input index, crossbar control.
REQ-011 SHALL have port o_out_busy  output  NUM_PORTS  per-output lock held.

Function
REQ-012 SHALL keep, per output, a 2-state FSM: FREE, LOCKED (wormhole lock).
REQ-013 An input SHALL be a candidate for output j when i_switch_req=1, i_route valid (MSB=0), i_route==j, and the input holds no lock.
REQ-014 Output j in FREE with i_out_ready[j]=1 and >=1 candidate SHALL grant exactly one candidate, chosen round-robin starting at its pointer rr[j].
REQ-015 Grant decided from inputs sampled at edge t SHALL register: o_switch_ack[i]=1 for the cycle after edge t only, output -> LOCKED, owner=i, rr[j]=(i+1) mod NUM_PORTS.
REQ-016 o_xbar_sel[j] SHALL equal owner index while LOCKED, and 0 while FREE; o_out_busy[j]=1 iff LOCKED.
REQ-017 LOCKED output SHALL return to FREE at the edge where i_packet_done[owner]=1; i_packet_done from non-owners SHALL be ignored.
REQ-018 Output released at edge t SHALL not grant before edge t+1 (no same-cycle regrant); release and new grant never overlap.
REQ-019 FREE output with i_out_ready[j]=0 SHALL not grant; pending requests remain and are served when ready returns.
REQ-020 Requests with invalid route or route >= NUM_PORTS SHALL be ignored, no ack.
REQ-021 An input SHALL own at most one output; o_switch_ack SHALL be at most one-hot per input.
REQ-022 A requesting input not granted SHALL receive no ack and be reconsidered every cycle; no starvation: any persistent candidate granted within NUM_PORTS-1 lock periods of its output.
REQ-023 rr[j] SHALL wrap from NUM_PORTS-1 to 0.

Reset
REQ-024 On reset_n=0, all outputs SHALL go FREE, rr[j]=0, o_switch_ack=0, o_xbar_sel=0, o_out_busy=0, immediately (asynchronous).
REQ-025 Reset mid-packet SHALL discard all locks; first grant after release no earlier than first edge with reset_n=1.

Structure
REQ-026 ALLOC_STATE_t (FREE, LOCKED), ROUTE_t, NUM_PORTS/NUM_OF_PORTS_BITS SHALL live in router_pkg.
REQ-027 Per-output arbitration SHALL be one sub-module rr_arbiter (NUM_PORTS request vector, pointer in, one-hot grant out), instantiated NUM_PORTS times.

Verification
REQ-028 Single: input 0 req route=2, ready all 1 -> ack[0] one cycle later, busy[2]=1, xbar_sel[2]=0; done[0] -> busy[2]=0 next cycle.
REQ-029 Contention: inputs 1,3,4 req route=0 together, rr[0]=0 -> grants in order 1,3,4, each after previous owner's done, one ack per lock.
REQ-030 Parallel: input 0->1, input 1->0, input 2->3 same cycle -> three acks same cycle, busy=0b01011.
REQ-031 Backpressure: ready[2]=0, input 4 req route=2 -> no ack for 10 cycles; ready[2]=1 -> ack[4] next cycle.
REQ-032 Boundaries: route=0b100 (invalid) -> no ack; done[3] while input 1 owns output 2 -> lock kept; done[1] with input 0 pending route=2 -> release edge t, ack[0] after edge t+1.
REQ-033 Reset: reset_n low during LOCKED -> busy, acks, sel zero asynchronously; rr pointers 0 after release.
